therm_encoder_pipe: RTL

THERM_ENCODER_PIPE -- requirements
Module: therm_encoder_pipe

---
 rtl/flash_adc_pkg.sv | 27 ++
 rtl/bubble_corrector.sv | 20 ++
 rtl/therm_encoder_pipe.sv | 103 ++++++++++
 3 files changed

// File: rtl/flash_adc_pkg.sv
// Shared sizing and helpers for the flash ADC thermometer encoder.
package flash_adc_pkg;

  localparam int unsigned BITS_DEFAULT = 3;
  localparam int unsigned ERRW_DEFAULT = 8;

  // Largest supported code width; popcount is sized for it.
  localparam int unsigned MAX_BITS = 6;
  localparam int unsigned MAX_COMP = (1 << MAX_BITS) - 1;
  localparam int unsigned POPW     = MAX_BITS + 1;

  // Comparator count for a given code width.
  function automatic int unsigned comp_of(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

  // Population count over the widest comparator bank; narrower banks are zero-extended.
  function automatic logic [POPW-1:0] popcount(input logic [MAX_COMP-1:0] v);
    logic [POPW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_COMP); i++) begin
      n = n + POPW'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bubble_corrector.sv
// Three-input majority bubble correction across a thermometer code.
module bubble_corrector #(
  parameter int unsigned COMP = 7
) (
  input  logic [COMP-1:0] therm,
  output logic [COMP-1:0] corr_c
);

  // Pad below with 1 and above with 0 so the end comparators see fixed neighbours.
  logic [COMP+1:0] ext;

  assign ext = {1'b0, therm, 1'b1};

  for (genvar i = 0; i < int'(COMP); i++) begin : g_maj
    assign corr_c[i] = (ext[i]   & ext[i+1]) |
                       (ext[i]   & ext[i+2]) |
                       (ext[i+1] & ext[i+2]);
  end

endmodule

// File: rtl/therm_encoder_pipe.sv
// Two-stage thermometer-to-binary encoder with bubble correction, error flagging,
// optional hold-last-good on error, and a saturating error counter.
module therm_encoder_pipe
  import flash_adc_pkg::*;
#(
  parameter int unsigned BITS         = BITS_DEFAULT,
  parameter int unsigned ERRW         = ERRW_DEFAULT,
  parameter bit          HOLD_DEFAULT = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [comp_of(BITS)-1:0]      therm,
  input  logic                          in_valid,
  input  logic                          hold_en,
  input  logic                          err_clr,
  output logic [BITS-1:0]               code,
  output logic                          out_valid,
  output logic                          err,
  output logic                          ovr,
  output logic [ERRW-1:0]               err_cnt
);

  localparam int unsigned COMP = comp_of(BITS);

  // ---------------------------------------------------------------- stage 1
  logic [COMP-1:0] corr_c;
  logic            raw_err_c;

  logic            s1_valid;
  logic [COMP-1:0] s1_corr;
  logic            s1_err;
  logic            hold_q;

  bubble_corrector #(.COMP(COMP)) u_bubble (
    .therm  (therm),
    .corr_c (corr_c)
  );

  // A clean code is 0..01..1; adding one then leaves no bit shared with the input.
  assign raw_err_c = |(therm & COMP'(therm + COMP'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_corr  <= '0;
      s1_err   <= 1'b0;
      hold_q   <= HOLD_DEFAULT;
    end else begin
      s1_valid <= in_valid;
      hold_q   <= hold_en;
      if (in_valid) begin
        s1_corr <= corr_c;
        s1_err  <= raw_err_c;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [BITS-1:0] pop_c;
  logic [BITS-1:0] code_nx_c;
  logic [BITS-1:0] last_good;

  // Corrected popcount, or the last good code when holding over an error sample.
  always_comb begin
    pop_c     = BITS'(popcount(MAX_COMP'(s1_corr)));
    code_nx_c = pop_c;
    if (s1_err && hold_q) begin
      code_nx_c = last_good;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      code      <= '0;
      err       <= 1'b0;
      ovr       <= 1'b0;
      last_good <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        code <= code_nx_c;
        err  <= s1_err;
        ovr  <= (code_nx_c == BITS'(COMP));
        if (!s1_err) begin
          last_good <= pop_c;
        end
      end
    end
  end

  // Clear takes priority over a coincident error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (s1_valid && s1_err && (err_cnt != {ERRW{1'b1}})) begin
      err_cnt <= err_cnt + ERRW'(1);
    end
  end

endmodule
